// File: rtl/id_issue_buffer.sv
// Instruction issue buffer: DEPTH-entry fetch FIFO, head pre-decode, N-source operand forwarding,
// load-use stall and a registered valid/ready issue port. Define ID_ISSUE_PERF_CNT_EN for a stall counter.
module id_issue_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_pc,
  input  logic [31:0]                   in_inst,
  input  logic                          flush,
  output logic [4:0]                    rf_raddr1,
  output logic [4:0]                    rf_raddr2,
  input  logic [DATA_W-1:0]             rf_rdata1,
  input  logic [DATA_W-1:0]             rf_rdata2,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [5*NUM_FWD-1:0]          fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0]     fwd_wdata,
  input  logic                          ex_is_load,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   out_inst,
  output logic [DATA_W-1:0]             out_rs_data,
  output logic [DATA_W-1:0]             out_rt_data,
  output logic                          out_wreg,
  output logic [4:0]                    out_wd,
  output logic                          out_in_delayslot,
  output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef ID_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     r_fifo_pc   [DEPTH];
  logic [31:0]     r_fifo_inst [DEPTH];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;

  logic              r_out_valid, r_out_wreg, r_out_ds, r_ds;
  logic [31:0]       r_out_pc, r_out_inst;
  logic [DATA_W-1:0] r_out_rs, r_out_rt;
  logic [4:0]        r_out_wd;

  logic [31:0]       w_inst;
  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd, w_wd, w_fwd0_addr;
  logic              w_reads_rs, w_reads_rt, w_writer, w_branch;
  logic              w_head_valid, w_hazard, w_push, w_issue;
  logic [DATA_W-1:0] w_rs_data, w_rt_data;

  assign w_head_valid = (r_count != '0);
  assign in_ready     = (r_count < CntW'(DEPTH));
  assign w_push       = in_valid & in_ready & ~flush;

  assign w_inst  = r_fifo_inst[r_rptr];
  assign w_op    = w_inst[31:26];
  assign w_rs    = w_inst[25:21];
  assign w_rt    = w_inst[20:16];
  assign w_rd    = w_inst[15:11];
  assign w_funct = w_inst[5:0];

  assign rf_raddr1 = w_rs;
  assign rf_raddr2 = w_rt;

  always_comb begin
    w_reads_rs = 1'b1;
    w_reads_rt = 1'b0;
    w_writer   = 1'b0;
    w_wd       = 5'd0;
    w_branch   = 1'b0;
    case (w_op)
      6'h00: begin
        w_reads_rt = 1'b1;
        w_writer   = 1'b1;
        w_wd       = w_rd;
        case (w_funct)
          6'h00, 6'h02, 6'h03: w_reads_rs = 1'b0;
          6'h08: begin w_reads_rt = 1'b0; w_writer = 1'b0; w_branch = 1'b1; end
          6'h09: begin w_reads_rt = 1'b0; w_branch = 1'b1; end
          6'h0c, 6'h0d, 6'h0f: begin
            w_reads_rs = 1'b0; w_reads_rt = 1'b0; w_writer = 1'b0;
          end
          6'h10, 6'h12: begin w_reads_rs = 1'b0; w_reads_rt = 1'b0; end
          6'h11, 6'h13: begin w_reads_rt = 1'b0; w_writer = 1'b0; end
          6'h18, 6'h19, 6'h1a, 6'h1b: w_writer = 1'b0;
          default: ;
        endcase
      end
      6'h01: begin
        // REGIMM: BLTZ/BGEZ/BLTZAL/BGEZAL; the -AL forms link into $31
        if (w_rt == 5'h00 || w_rt == 5'h01 || w_rt == 5'h10 || w_rt == 5'h11) w_branch = 1'b1;
        if (w_rt == 5'h10 || w_rt == 5'h11) begin w_writer = 1'b1; w_wd = 5'd31; end
      end
      6'h02: begin w_reads_rs = 1'b0; w_branch = 1'b1; end
      6'h03: begin w_reads_rs = 1'b0; w_branch = 1'b1; w_writer = 1'b1; w_wd = 5'd31; end
      6'h04, 6'h05: begin w_reads_rt = 1'b1; w_branch = 1'b1; end
      6'h06, 6'h07: w_branch = 1'b1;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin w_writer = 1'b1; w_wd = w_rt; end
      6'h0f: begin w_reads_rs = 1'b0; w_writer = 1'b1; w_wd = w_rt; end
      6'h10: begin
        w_reads_rs = 1'b0;
        if (w_rs == 5'h00) begin w_writer = 1'b1; w_wd = w_rt; end
        if (w_rs == 5'h04) w_reads_rt = 1'b1;
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin w_writer = 1'b1; w_wd = w_rt; end
      6'h28, 6'h29, 6'h2b: w_reads_rt = 1'b1;
      default: ;
    endcase
  end

  // Iterate from lowest priority upward so the lowest-index match overwrites last.
  always_comb begin
    w_rs_data = rf_rdata1;
    w_rt_data = rf_rdata2;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == w_rs) w_rs_data = fwd_wdata[DATA_W*i +: DATA_W];
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == w_rt) w_rt_data = fwd_wdata[DATA_W*i +: DATA_W];
    end
    if (w_rs == 5'd0) w_rs_data = '0;
    if (w_rt == 5'd0) w_rt_data = '0;
  end

  assign w_fwd0_addr = fwd_waddr[4:0];
  assign w_hazard = ex_is_load & fwd_we[0] & (w_fwd0_addr != 5'd0) &
                    ((w_reads_rs & (w_rs == w_fwd0_addr)) | (w_reads_rt & (w_rt == w_fwd0_addr)));
  assign w_issue  = w_head_valid & ~w_hazard & (~r_out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]   <= in_pc;
      r_fifo_inst[r_wptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_out_rs    <= '0;
      r_out_rt    <= '0;
      r_out_wreg  <= 1'b0;
      r_out_wd    <= '0;
      r_out_ds    <= 1'b0;
      r_ds        <= 1'b0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_ds        <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= r_fifo_pc[r_rptr];
        r_out_inst  <= w_inst;
        r_out_rs    <= w_rs_data;
        r_out_rt    <= w_rt_data;
        r_out_wreg  <= w_writer & (w_wd != 5'd0);
        r_out_wd    <= w_writer ? w_wd : 5'd0;
        r_out_ds    <= r_ds;
        r_ds        <= w_branch;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ID_ISSUE_PERF_CNT_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if (w_head_valid && w_hazard && r_perf != 32'hFFFF_FFFF) begin
      r_perf <= r_perf + 32'd1;
    end
  end
  assign perf_stall_cnt = r_perf;
`endif

  assign out_valid        = r_out_valid;
  assign out_pc           = r_out_pc;
  assign out_inst         = r_out_inst;
  assign out_rs_data      = r_out_rs;
  assign out_rt_data      = r_out_rt;
  assign out_wreg         = r_out_wreg;
  assign out_wd           = r_out_wd;
  assign out_in_delayslot = r_out_ds;
  assign count            = r_count;

endmodule

// File: tb/tb_id_issue_buffer.sv
// Scoreboard bench for id_issue_buffer: expected issues are queued at push and compared at handshake.
module tb_id_issue_buffer;

  localparam int DEPTH   = 4;
  localparam int NUM_FWD = 3;
  localparam int DATA_W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, flush, ex_is_load, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [4:0] rf_raddr1, rf_raddr2, out_wd;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, out_rs_data, out_rt_data;
  logic [NUM_FWD-1:0] fwd_we;
  logic [5*NUM_FWD-1:0] fwd_waddr;
  logic [DATA_W*NUM_FWD-1:0] fwd_wdata;
  logic out_wreg, out_in_delayslot;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef ID_ISSUE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  // Regfile model: tagged read data so the source of every operand is visible.
  assign rf_rdata1 = 32'hA000_0000 | {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'hB000_0000 | {27'd0, rf_raddr2};

  id_issue_buffer #(.DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .ex_is_load(ex_is_load), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_wreg(out_wreg), .out_wd(out_wd),
    .out_in_delayslot(out_in_delayslot), .count(count)
`ifdef ID_ISSUE_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  wd;
    logic        wreg;
    logic        ds;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra_issue", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("issue_pc", out_pc, e.pc);
        check("issue_inst", out_inst, e.inst);
        check("issue_rs", out_rs_data, e.rs);
        check("issue_rt", out_rt_data, e.rt);
        check("issue_wreg", 32'(out_wreg), 32'(e.wreg));
        if (e.wreg) check("issue_wd", 32'(out_wd), 32'(e.wd));
        check("issue_ds", 32'(out_in_delayslot), 32'(e.ds));
      end
    end
  end

  function automatic logic [31:0] addu(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] rs_d,
                      input logic [31:0] rt_d, input logic [4:0] wd, input logic wreg,
                      input logic ds);
    exp_t e;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.pc = pc; e.inst = inst; e.rs = rs_d; e.rt = rt_d;
        e.wd = wd; e.wreg = wreg; e.ds = ds;
        sb.push_back(e);
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_empty(input int max_cycles);
    for (int k = 0; k < max_cycles && sb.size() != 0; k++) step();
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0;
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; ex_is_load = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_rs", out_rs_data, 32'd0);
    check("rst_ds", 32'(out_in_delayslot), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();

    // Fill with out_ready low, then drain one per cycle.
    for (int i = 0; i < 4; i++)
      push(32'h100 + 32'(4 * i), addu(5'(3 + i), 5'd1, 5'd2), 32'hA000_0001, 32'hB000_0002,
           5'(3 + i), 1'b1, 1'b0);
    @(negedge clk);
    check("fill_count3", 32'(count), 32'd3);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    step();
    push(32'h110, addu(5'd7, 5'd1, 5'd2), 32'hA000_0001, 32'hB000_0002, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    check("full_count4", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b1; in_pc = 32'h114; in_inst = addu(5'd9, 5'd1, 5'd2);
    @(negedge clk);
    check("full_hold_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    check("full_hold_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_count", 32'(count), 32'(4 - i));
    end
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    step();

    // Forwarding priority and register-0 handling.
    fwd_we = 3'b111; fwd_waddr = {5'd1, 5'd2, 5'd1}; fwd_wdata = {32'd9, 32'd7, 32'd5};
    push(32'h200, addu(5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    wait_empty(10);
    fwd_we = 3'b110; fwd_waddr = {5'd9, 5'd2, 5'd2}; fwd_wdata = {32'h99, 32'd7, 32'h55};
    push(32'h204, addu(5'd6, 5'd2, 5'd9), 32'd7, 32'h99, 5'd6, 1'b1, 1'b0);
    wait_empty(10);
    fwd_we = 3'b011; fwd_waddr = {5'd3, 5'd3, 5'd0}; fwd_wdata = {32'h77, 32'h33, 32'h55};
    push(32'h208, addu(5'd8, 5'd0, 5'd3), 32'd0, 32'h33, 5'd8, 1'b1, 1'b0);
    wait_empty(10);
    fwd_we = 3'b000;
    push(32'h20c, addu(5'd0, 5'd1, 5'd2), 32'hA000_0001, 32'hB000_0002, 5'd0, 1'b0, 1'b0);
    wait_empty(10);

    // Load-use stall for one cycle.
    ex_is_load = 1'b1; fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd4};
    fwd_wdata = {32'd0, 32'd0, 32'h44};
    push(32'h300, addu(5'd5, 5'd4, 5'd0), 32'h44, 32'd0, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    check("lu_held_valid", 32'(out_valid), 32'd0);
    check("lu_held_count", 32'(count), 32'd1);
    step();
    ex_is_load = 1'b0;
`ifdef ID_ISSUE_PERF_CNT_EN
    @(negedge clk);
    check("perf_stall", perf_stall_cnt, 32'd1);
`endif
    wait_empty(10);
    // LUI does not read rs, so a load into its rs field must not stall it.
    ex_is_load = 1'b1;
    push(32'h304, itype(6'h0f, 5'd4, 5'd6, 16'h1234), 32'h44, 32'hB000_0006, 5'd6, 1'b1, 1'b0);
    wait_empty(4);
    ex_is_load = 1'b0; fwd_we = 3'b000;

    // Delay-slot tracking.
    push(32'h400, itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'hA000_0001, 32'hB000_0002,
         5'd0, 1'b0, 1'b0);
    push(32'h404, itype(6'h09, 5'd1, 5'd3, 16'd5), 32'hA000_0001, 32'hB000_0003,
         5'd3, 1'b1, 1'b1);
    push(32'h408, itype(6'h0d, 5'd0, 5'd4, 16'd1), 32'd0, 32'hB000_0004, 5'd4, 1'b1, 1'b0);
    push(32'h40c, 32'h0C00_0000, 32'd0, 32'd0, 5'd31, 1'b1, 1'b0);
    push(32'h410, 32'h0000_0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    wait_empty(10);

    // Flush with a simultaneous push.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h500 + 32'(4 * i), addu(5'd3, 5'd1, 5'd2), 32'hA000_0001, 32'hB000_0002,
           5'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_flush_count", 32'(count), 32'd3);
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    step();
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h5FC; in_inst = addu(5'd9, 5'd1, 5'd2);
    sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_absent", 32'(out_valid), 32'd0);
    end
    step();

    // Asynchronous reset while draining.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'h600 + 32'(4 * i), addu(5'd4, 5'd1, 5'd2), 32'hA000_0001, 32'hB000_0002,
           5'd4, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_pc", out_pc, 32'd0);
    check("arst_out_inst", out_inst, 32'd0);
    check("arst_out_rt", out_rt_data, 32'd0);
    check("arst_out_wd", 32'(out_wd), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_arst_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
